// File: rtl/pcie_ingress_parser_if.sv
// Bus bundle for the PCIe ingress parser: the RX AXI-Stream beat channel from the
// PCIe core and the write port into the ingress ping-pong FIFO.
interface pcie_ingress_parser_if;
  logic [31:0] i_axi_ingress_data;
  logic [3:0]  i_axi_ingress_keep;
  logic        i_axi_ingress_last;
  logic        i_axi_ingress_valid;
  logic        o_axi_ingress_ready;
  logic        i_fifo_rdy;
  logic        o_fifo_act;
  logic [23:0] i_fifo_size;
  logic        o_fifo_stb;
  logic [31:0] o_fifo_data;

  // Handshake: a beat transfers on a rising clk edge where valid and ready are both high;
  // ready never looks at valid, and data/keep/last are only meaningful while valid is high.
  modport slave (
    input  i_axi_ingress_data,
    input  i_axi_ingress_keep,
    input  i_axi_ingress_last,
    input  i_axi_ingress_valid,
    output o_axi_ingress_ready,
    input  i_fifo_rdy,
    output o_fifo_act,
    input  i_fifo_size,
    output o_fifo_stb,
    output o_fifo_data
  );

  modport master (
    output i_axi_ingress_data,
    output i_axi_ingress_keep,
    output i_axi_ingress_last,
    output i_axi_ingress_valid,
    input  o_axi_ingress_ready,
    output i_fifo_rdy,
    input  o_fifo_act,
    output i_fifo_size,
    input  o_fifo_stb,
    input  o_fifo_data
  );
endinterface

// File: rtl/pcie_ingress_parser.sv
// PCIe RX TLP parser: decodes 3/4-DWORD headers and streams MWR/CPLD payload into
// the ingress FIFO, one TLP per i_enable grant.
module pcie_ingress_parser (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  output logic                  o_finished,
  pcie_ingress_parser_if.slave  bus,
  output logic                  o_hdr_stb,
  output logic [7:0]            o_command,
  output logic [13:0]           o_flags,
  output logic [9:0]            o_dword_cnt,
  output logic [15:0]           o_requester_id,
  output logic [7:0]            o_tag,
  output logic [2:0]            o_cpl_status,
  output logic [11:0]           o_byte_count,
  output logic [63:0]           o_address,
  output logic                  o_drop_pkt,
  output logic                  o_error,
  output logic [3:0]            o_state
);
  typedef enum logic [3:0] {
    IDLE          = 4'd0,
    READ_HDR      = 4'd1,
    WAIT_FOR_FIFO = 4'd2,
    READ_DATA     = 4'd3,
    DROP          = 4'd4,
    FINISHED      = 4'd5
  } state_t;

  localparam logic [7:0] CMD_MWR32 = 8'h40;
  localparam logic [7:0] CMD_MWR64 = 8'h60;
  localparam logic [7:0] CMD_CPLD  = 8'h4A;
  localparam logic [7:0] CMD_CPL   = 8'h0A;

  state_t      state, state_nxt;
  logic [31:0] hdr_q0, hdr_q1, hdr_q2;
  logic [1:0]  hdr_idx;
  logic        is4_q;
  logic [23:0] buf_cnt;
  logic [10:0] pkt_cnt;
  logic [10:0] dcnt_q;
  logic        fifo_act_q, fifo_stb_q;
  logic [31:0] fifo_data_q;

  logic        ready_c, accept;
  logic        hdr_wr, hdr_done, err_set, drop_set, act_set, fifo_wr;
  logic [31:0] h0, h1, h2;
  logic        is4_cur;
  logic [1:0]  last_idx;
  logic [7:0]  cmd;
  logic        is_data_cmd;
  logic [10:0] dcnt_dec;
  logic [15:0] f_req;
  logic [7:0]  f_tag;
  logic [2:0]  f_status;
  logic [11:0] f_bc;
  logic [63:0] f_addr;
  logic        unused_ok;

  assign unused_ok = ^{bus.i_axi_ingress_keep, h1[12]};

  assign ready_c = (state == READ_HDR) || (state == DROP) ||
                   ((state == READ_DATA) && (buf_cnt < bus.i_fifo_size));
  assign accept  = bus.i_axi_ingress_valid && ready_c;

  assign bus.o_axi_ingress_ready = ready_c;
  assign bus.o_fifo_act          = fifo_act_q;
  assign bus.o_fifo_stb          = fifo_stb_q;
  assign bus.o_fifo_data         = fifo_data_q;
  assign o_finished              = (state == FINISHED);
  assign o_state                 = state;

  // The final header beat is still on the bus, so the header view splices it in live.
  assign h0 = (hdr_idx == 2'd0) ? bus.i_axi_ingress_data : hdr_q0;
  assign h1 = (hdr_idx == 2'd1) ? bus.i_axi_ingress_data : hdr_q1;
  assign h2 = (hdr_idx == 2'd2) ? bus.i_axi_ingress_data : hdr_q2;

  assign is4_cur     = (hdr_idx == 2'd0) ? bus.i_axi_ingress_data[29] : is4_q;
  assign last_idx    = is4_cur ? 2'd3 : 2'd2;
  assign cmd         = h0[31:24];
  assign is_data_cmd = (cmd == CMD_MWR32) || (cmd == CMD_MWR64) || (cmd == CMD_CPLD);
  assign dcnt_dec    = (h0[9:0] == 10'd0) ? 11'd1024 : {1'b0, h0[9:0]};

  always_comb begin
    f_req    = h1[31:16];
    f_tag    = h1[15:8];
    f_status = 3'd0;
    f_bc     = 12'd0;
    f_addr   = 64'd0;
    case (cmd)
      CMD_MWR32: f_addr = {32'h0, h2[31:2], 2'b00};
      CMD_MWR64: f_addr = {h2, bus.i_axi_ingress_data[31:2], 2'b00};
      CMD_CPL, CMD_CPLD: begin
        f_req    = h2[31:16];
        f_tag    = h2[15:8];
        f_status = h1[15:13];
        f_bc     = h1[11:0];
        f_addr   = {57'h0, h2[6:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hdr_wr    = 1'b0;
    hdr_done  = 1'b0;
    err_set   = 1'b0;
    drop_set  = 1'b0;
    act_set   = 1'b0;
    fifo_wr   = 1'b0;
    case (state)
      IDLE: if (i_enable) state_nxt = READ_HDR;
      READ_HDR: begin
        if (accept) begin
          hdr_wr = 1'b1;
          if (hdr_idx == last_idx) begin
            hdr_done = 1'b1;
            if (is_data_cmd) begin
              // A data TLP ending on its header has no payload to match its length.
              if (bus.i_axi_ingress_last) begin
                err_set   = 1'b1;
                state_nxt = FINISHED;
              end else begin
                state_nxt = WAIT_FOR_FIFO;
              end
            end else if (cmd == CMD_CPL) begin
              err_set   = !bus.i_axi_ingress_last;
              state_nxt = FINISHED;
            end else begin
              drop_set  = 1'b1;
              state_nxt = bus.i_axi_ingress_last ? FINISHED : DROP;
            end
          end else if (bus.i_axi_ingress_last) begin
            err_set   = 1'b1;
            state_nxt = FINISHED;
          end
        end
      end
      WAIT_FOR_FIFO: begin
        if (bus.i_fifo_rdy && !fifo_act_q) begin
          act_set   = 1'b1;
          state_nxt = READ_DATA;
        end
      end
      READ_DATA: begin
        if (buf_cnt >= bus.i_fifo_size) begin
          state_nxt = WAIT_FOR_FIFO;
        end else if (accept) begin
          fifo_wr = 1'b1;
          if (bus.i_axi_ingress_last) begin
            err_set   = ((pkt_cnt + 11'd1) != dcnt_q);
            state_nxt = FINISHED;
          end else if ((pkt_cnt + 11'd1) == dcnt_q) begin
            err_set   = 1'b1;
            state_nxt = DROP;
          end else if ((buf_cnt + 24'd1) == bus.i_fifo_size) begin
            state_nxt = WAIT_FOR_FIFO;
          end
        end
      end
      DROP: if (accept && bus.i_axi_ingress_last) state_nxt = FINISHED;
      FINISHED: if (!i_enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q0         <= 32'd0;
      hdr_q1         <= 32'd0;
      hdr_q2         <= 32'd0;
      hdr_idx        <= 2'd0;
      is4_q          <= 1'b0;
      buf_cnt        <= 24'd0;
      pkt_cnt        <= 11'd0;
      dcnt_q         <= 11'd0;
      fifo_act_q     <= 1'b0;
      fifo_stb_q     <= 1'b0;
      fifo_data_q    <= 32'd0;
      o_hdr_stb      <= 1'b0;
      o_command      <= 8'd0;
      o_flags        <= 14'd0;
      o_dword_cnt    <= 10'd0;
      o_requester_id <= 16'd0;
      o_tag          <= 8'd0;
      o_cpl_status   <= 3'd0;
      o_byte_count   <= 12'd0;
      o_address      <= 64'd0;
      o_drop_pkt     <= 1'b0;
      o_error        <= 1'b0;
    end else begin
      o_hdr_stb  <= hdr_done;
      o_error    <= err_set;
      o_drop_pkt <= drop_set;
      fifo_stb_q <= fifo_wr;
      if (fifo_wr) fifo_data_q <= bus.i_axi_ingress_data;

      // Outside READ_DATA the buffer is released one cycle after the last strobe.
      if (act_set)                 fifo_act_q <= 1'b1;
      else if (state != READ_DATA) fifo_act_q <= 1'b0;

      if (state == IDLE) begin
        hdr_idx <= 2'd0;
        pkt_cnt <= 11'd0;
        buf_cnt <= 24'd0;
      end

      if (hdr_wr) begin
        case (hdr_idx)
          2'd0: begin
            hdr_q0 <= bus.i_axi_ingress_data;
            is4_q  <= bus.i_axi_ingress_data[29];
          end
          2'd1:    hdr_q1 <= bus.i_axi_ingress_data;
          2'd2:    hdr_q2 <= bus.i_axi_ingress_data;
          default: ;
        endcase
        hdr_idx <= hdr_idx + 2'd1;
      end

      if (hdr_done) begin
        o_command      <= cmd;
        o_flags        <= h0[23:10];
        o_dword_cnt    <= h0[9:0];
        o_requester_id <= f_req;
        o_tag          <= f_tag;
        o_cpl_status   <= f_status;
        o_byte_count   <= f_bc;
        o_address      <= f_addr;
        dcnt_q         <= dcnt_dec;
      end

      if (act_set)      buf_cnt <= 24'd0;
      else if (fifo_wr) buf_cnt <= buf_cnt + 24'd1;
      if (fifo_wr)      pkt_cnt <= pkt_cnt + 11'd1;
    end
  end
endmodule

// File: doc/pcie_ingress_parser.md
# pcie_ingress_parser

Host-to-device receive path of the TX1 PCIe host interface. Accepts TLPs from the PCIe core's 32-bit AXI-Stream RX port, parses the 3- or 4-DWORD header, and exposes decoded header fields to the controller. Payload DWORDs of memory writes (MWR 32/64) and completions-with-data (CPLD) are streamed into the ingress ping-pong FIFO. Header-only completions (CPL) and all other TLP types are consumed; unsupported types are discarded and flagged.

## Interface
- Parameters: none.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_enable  in  1  controller permits reception of one TLP; must stay high until o_finished
- o_finished  out  1  TLP fully consumed; held until i_enable low
- i_axi_ingress_data  in  32  RX stream data
- i_axi_ingress_keep  in  4  ignored (DWORD-granular stream)
- i_axi_ingress_last  in  1  final beat of TLP
- i_axi_ingress_valid  in  1  beat valid
- o_axi_ingress_ready  out  1  beat accept
- o_hdr_stb  out  1  one-cycle pulse: header fields below valid
- o_command  out  8  hdr0[31:24] (fmt/type)
- o_flags  out  14  hdr0[23:10]
- o_dword_cnt  out  10  hdr0[9:0]; 0 decodes as 1024 for data TLPs
- o_requester_id  out  16  MWR: hdr1[31:16]; CPL/CPLD: hdr2[31:16]
- o_tag  out  8  MWR: hdr1[15:8]; CPL/CPLD: hdr2[15:8]
- o_cpl_status  out  3  CPL/CPLD hdr1[15:13]; 0 otherwise
- o_byte_count  out  12  CPL/CPLD hdr1[11:0]; 0 otherwise
- o_address  out  64  MWR32: {32'h0, hdr2[31:2], 2'b00}; MWR64: {hdr2, hdr3[31:2], 2'b00}; CPL/CPLD: {57'h0, hdr2[6:0]}
- i_fifo_rdy  in  1  a FIFO buffer is available
- o_fifo_act  out  1  buffer held
- i_fifo_size  in  24  capacity of held buffer, DWORDs
- o_fifo_stb  out  1  write strobe
- o_fifo_data  out  32  write data
- o_drop_pkt  out  1  one-cycle pulse: unsupported type discarded
- o_error  out  1  one-cycle pulse: length mismatch / premature last
- o_state  out  4  current state (debug)

## Operation
- States: IDLE=0, READ_HDR=1, WAIT_FOR_FIFO=2, READ_DATA=3, DROP=4, FINISHED=5; undefined encodings -> IDLE.
- IDLE: ready=0, finished=0, counters cleared. i_enable -> READ_HDR.
- READ_HDR: ready=1. Accepted beats stored at index 0..N-1; N=4 if hdr0[29] else 3 (decided on beat 0). After beat N-1: o_hdr_stb pulses, fields registered. Next state by o_command: 8'h40/8'h60/8'h4A -> WAIT_FOR_FIFO; 8'h0A -> FINISHED (error if last not asserted on beat N-1); anything else -> DROP with o_drop_pkt pulse (or FINISHED if that beat had last).
- last on a header beat before N-1: o_error pulse, FINISHED.
- WAIT_FOR_FIFO: ready=0. i_fifo_rdy && !o_fifo_act -> o_fifo_act=1, buffer count=0, READ_DATA.
- READ_DATA: ready=1 while buffer count < i_fifo_size. Each accepted beat: o_fifo_data<=data, o_fifo_stb<=1, buffer count++, packet count++ (11-bit).
  - Beat with last: o_fifo_act<=0, FINISHED; o_error pulse if packet count+1 != decoded dword count.
  - Buffer count reaches i_fifo_size without last: ready drops same cycle, o_fifo_act<=0, WAIT_FOR_FIFO (packet count retained).
  - Packet count reaching dword count without last: o_error; remaining beats discarded via DROP.
- DROP: ready=1, beats discarded until last accepted -> FINISHED.
- FINISHED: ready=0, o_fifo_act=0, o_finished=1; !i_enable -> IDLE.

## Timing
- Reset values: all outputs 0, state IDLE.
- ready is combinational from state and buffer count; no beat accepted while ready=0.
- o_hdr_stb and header fields: 1 cycle after last header beat accepted; fields held until next header.
- o_fifo_stb/o_fifo_data: 1 cycle after beat accepted; throughput 1 DWORD/cycle.
- o_fifo_act released the cycle after the final write strobe is issued; re-acquire no sooner than next cycle.
- i_fifo_size=0 while held: no beats accepted, act released, back to WAIT_FOR_FIFO.
- Reset mid-packet: immediate return to IDLE, act released; remaining RX beats seen as a new TLP.

## Test plan
- MWR32, hdr {0x40000004, 0x01000FFF, 0x00001000}, 4 data beats, fifo size 512 -> fields addr 0x1000, dword_cnt 4; 4 stb with matching data; finished; no error.
- CPLD 3DW, dword_cnt 600, fifo size 512 -> 512 stbs, act drops, re-acquire, 88 stbs; status/tag/byte_count decoded.
- CPL (0x0A), 3 beats with last on beat 2 -> hdr_stb, no fifo_act, finished.
- Type 0x00 (MRD32) with last on hdr2 -> o_drop_pkt pulse, FINISHED, no stb.
- MWR64 dword_cnt 8, last on 5th data beat -> 5 stbs, o_error pulse; valid toggling randomly -> no lost/duplicated beats.
- Reset asserted during READ_DATA -> next cycle all outputs 0, state IDLE.
